output_port_alloc: RTL

Wormhole output-port allocator for one router output: shares a single crossbar output among `NUM_IN` input ports using a least-recently-granted matrix arbiter. It locks the port to the winning packet from head to tail flit and gates every flit transfer on downstream credits. One instance sits per router output, driving the crossbar select and the output link valid.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/lrg_matrix_arb.sv | 37 +++
 rtl/output_port_alloc.sv | 132 +++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types: allocator FSM states, default sizing, port-index helpers.
// Latency: none (types and pure functions only).
// Backpressure: none.
package noc_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    localparam int NUM_IN_DEF  = 5;
    localparam int CREDITS_DEF = 4;

    // Wide enough for the largest supported router radix (8 inputs).
    typedef logic [2:0] port_idx_t;

    function automatic port_idx_t onehot_to_idx(input logic [7:0] oh);
        port_idx_t idx;
        idx = '0;
        for (int k = 0; k < 8; k++) begin
            if (oh[k]) idx = port_idx_t'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lrg_matrix_arb.sv
// N-input least-recently-granted matrix arbiter with registered priority matrix.
// Latency: request-to-grant is combinational; priority updates on the edge after a grant.
// Backpressure: none; the caller masks requests and enables update only on accepted grants.
module lrg_matrix_arb #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] gnt
);

    // beats[i][j] = 1 means requester i wins over requester j.
    logic [N-1:0] beats [N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (i > j) begin : g_lo
                logic p;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        p <= 1'b1;
                    end else if (update && (gnt[i] || gnt[j])) begin
                        p <= gnt[j];
                    end
                end
                assign beats[i][j] = p;
                assign beats[j][i] = ~p;
            end else if (i == j) begin : g_diag
                assign beats[i][j] = 1'b1;
            end
        end
        assign gnt[i] = req[i] & (&(beats[i] | ~req));
    end

endmodule

// File: rtl/output_port_alloc.sv
// Wormhole output-port allocator: LRG arbitration on heads, head-to-tail lock, credit gating (OPA_WATCHDOG_EN adds a stall watchdog).
// Latency: gnt/sel/xfer are zero-cycle combinational; state, owner, priority and credits update on the next edge.
// Backpressure: no flit is granted while credit_cnt is 0; ungranted inputs hold their flit.
module output_port_alloc
    import noc_pkg::*;
#(
    parameter int NUM_IN  = NUM_IN_DEF,
    parameter int CREDITS = CREDITS_DEF
`ifdef OPA_WATCHDOG_EN
    , parameter int WD_CYCLES = 64
`endif
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_IN-1:0]                  req_valid,
    input  logic [NUM_IN-1:0]                  req_head,
    input  logic [NUM_IN-1:0]                  req_tail,
    input  logic                               credit_return,
    output logic [NUM_IN-1:0]                  gnt,
    output logic                               xfer,
    output logic [NUM_IN-1:0]                  sel,
    output logic [$clog2(CREDITS+1)-1:0]       credit_cnt,
    output logic                               locked,
    output logic [$clog2(NUM_IN)-1:0]          owner,
    output logic                               wd_err
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int OW = $clog2(NUM_IN);

    alloc_state_t    state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   win_idx;
    logic            cred_ok;
    logic            tail_hit;
    logic            wd_fire;
    logic [NUM_IN-1:0] arb_req, arb_gnt;
    logic            arb_update;

    assign cred_ok = (credit_cnt != '0);

    // Only heads compete, and only when the port is free and a credit is available.
    assign arb_req    = (state_q == IDLE && cred_ok) ? (req_valid & req_head) : '0;
    assign arb_update = (state_q == IDLE) && xfer;

    lrg_matrix_arb #(.N(NUM_IN)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (arb_req),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    always_comb begin
        gnt = '0;
        if (state_q == IDLE) begin
            gnt = arb_gnt;
        end else begin
            gnt = req_valid & (NUM_IN'(1) << owner_q) & {NUM_IN{cred_ok}};
        end
    end

    assign xfer     = |gnt;
    assign sel      = gnt;
    assign tail_hit = |(gnt & req_tail);
    assign win_idx  = OW'(onehot_to_idx(8'(gnt)));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (state_q == IDLE) begin
            if (xfer && !tail_hit) begin
                state_d = LOCKED;
                owner_d = win_idx;
            end
        end else if (xfer && tail_hit) begin
            state_d = IDLE;
        end
        if (wd_fire) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            credit_cnt <= CW'(CREDITS);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (xfer && !credit_return) begin
                credit_cnt <= credit_cnt - 1'b1;
            end else if (!xfer && credit_return && credit_cnt != CW'(CREDITS)) begin
                credit_cnt <= credit_cnt + 1'b1;
            end
        end
    end

    assign locked = (state_q == LOCKED);
    assign owner  = owner_q;

`ifdef OPA_WATCHDOG_EN
    localparam int WW = $clog2(WD_CYCLES + 1);

    logic [WW-1:0] wd_cnt;
    logic          wd_err_q;
    logic          stalled;

    // Counter holds at WD_CYCLES-1 while credits are empty; the abort waits for a credit.
    assign stalled = (state_q == LOCKED) && !xfer;
    assign wd_fire = stalled && cred_ok && (wd_cnt >= WW'(WD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if (!stalled || wd_fire) begin
                wd_cnt <= '0;
            end else if (wd_cnt < WW'(WD_CYCLES - 1)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) wd_err_q <= 1'b1;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_fire = 1'b0;
    assign wd_err  = 1'b0;
`endif

endmodule
